// File: rtl/lsu_mmio_if.sv
// Core-side load/store bus between the execute stage and the LSU.
// The core drives requests; the LSU returns load data and the misalign flag.
interface lsu_mmio_if;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct3_i;
  logic        ld_en_i;
  logic        st_en_i;
  logic [31:0] ld_data_o;
  logic        ld_valid_o;
  logic        misalign_o;

  modport master (
    output addr_i, wdata_i, funct3_i, ld_en_i, st_en_i,
    input  ld_data_o, ld_valid_o, misalign_o
  );

  modport slave (
    input  addr_i, wdata_i, funct3_i, ld_en_i, st_en_i,
    output ld_data_o, ld_valid_o, misalign_o
  );
endinterface

// File: rtl/lsu_mmio.sv
// Load/store unit with memory-mapped board I/O for the single-cycle RV32I core.
// Decodes data memory, LED/HEX/LCD output registers and synchronised switches,
// handles B/H/W sizing with byte-lane masking, registered loads and misalign flagging.
module lsu_mmio #(
  parameter int DMEM_WORDS = 512,
  parameter int N_HEX      = 8,
  parameter int SW_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lsu_mmio_if.slave          bus,
  input  logic [SW_W-1:0]    io_sw_i,
  output logic [31:0]        io_ledr_o,
  output logic [31:0]        io_ledg_o,
  output logic [7*N_HEX-1:0] io_hex_o,
  output logic [31:0]        io_lcd_o
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  // Merge new bytes into an existing word under a byte-enable mask.
  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]            dmem_r [DMEM_WORDS];
  logic [31:0]            ledr_r, ledg_r, lcd_r;
  logic [N_HEX-1:0][6:0]  hex_r;
  logic [SW_W-1:0]        sw_meta_r, sw_sync_r;
  logic [31:0]            ld_data_r;
  logic                   ld_valid_r, misalign_r;

  logic [31:0]   off_s, word_addr_s, wdata_rep_s, rd_word_s, sw_ext_s, ld_result_s;
  logic [AW-1:0] dmem_idx_s;
  logic [2:0]    hex_idx_s;
  logic [6:0]    hex_rd_s;
  logic [15:0]   lane_s;
  logic [3:0]    be_s;
  logic          align_ok_s, store_ok_s;
  logic          is_dmem_s, is_ledr_s, is_ledg_s, is_hex_s, is_lcd_s, is_sw_s;

  // Address decode: regions are matched on the word address so sub-word accesses hit the same register.
  always_comb begin
    off_s       = bus.addr_i - DMEM_BASE;
    word_addr_s = {bus.addr_i[31:2], 2'b00};
    is_dmem_s   = (bus.addr_i >= DMEM_BASE) && (off_s < DMEM_BYTES);
    dmem_idx_s  = off_s[AW+1:2];
    hex_idx_s   = bus.addr_i[4:2];
    is_ledr_s   = (word_addr_s == 32'h0000_7000);
    is_ledg_s   = (word_addr_s == 32'h0000_7010);
    is_lcd_s    = (word_addr_s == 32'h0000_7040);
    is_sw_s     = (word_addr_s == 32'h0000_7800);
    is_hex_s    = (bus.addr_i[31:5] == 27'h000_0381) && ({29'd0, hex_idx_s} < 32'(N_HEX));
  end

  // Size decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    case (bus.funct3_i)
      3'b000, 3'b100: begin
        align_ok_s = 1'b1;
        be_s       = 4'b0001 << bus.addr_i[1:0];
      end
      3'b001, 3'b101: begin
        align_ok_s = ~bus.addr_i[0];
        be_s       = bus.addr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        align_ok_s = (bus.addr_i[1:0] == 2'b00);
        be_s       = 4'b1111;
      end
      default: begin
        align_ok_s = 1'b0;
        be_s       = 4'b0000;
      end
    endcase
    case (bus.funct3_i[1:0])
      2'b00:   wdata_rep_s = {4{bus.wdata_i[7:0]}};
      2'b01:   wdata_rep_s = {2{bus.wdata_i[15:0]}};
      default: wdata_rep_s = bus.wdata_i;
    endcase
    store_ok_s = bus.st_en_i && align_ok_s;
  end

  // Read path: select the addressed word, then extract and extend the requested lane.
  always_comb begin
    sw_ext_s             = 32'h0;
    sw_ext_s[SW_W-1:0]   = sw_sync_r;
    hex_rd_s             = 7'h00;
    for (int i = 0; i < N_HEX; i++) begin
      if (hex_idx_s == 3'(i)) begin
        hex_rd_s = hex_r[i];
      end else begin
        hex_rd_s = hex_rd_s;
      end
    end
    if (is_dmem_s)      rd_word_s = dmem_r[dmem_idx_s];
    else if (is_ledr_s) rd_word_s = ledr_r;
    else if (is_ledg_s) rd_word_s = ledg_r;
    else if (is_hex_s)  rd_word_s = {25'd0, hex_rd_s};
    else if (is_lcd_s)  rd_word_s = lcd_r;
    else if (is_sw_s)   rd_word_s = sw_ext_s;
    else                rd_word_s = 32'h0;
    lane_s = 16'(rd_word_s >> {bus.addr_i[1:0], 3'b000});
    case (bus.funct3_i)
      3'b000:  ld_result_s = {{24{lane_s[7]}}, lane_s[7:0]};
      3'b001:  ld_result_s = {{16{lane_s[15]}}, lane_s};
      3'b010:  ld_result_s = rd_word_s;
      3'b100:  ld_result_s = {24'd0, lane_s[7:0]};
      3'b101:  ld_result_s = {16'd0, lane_s};
      default: ld_result_s = 32'h0;
    endcase
    if (!align_ok_s) ld_result_s = 32'h0;
    else             ld_result_s = ld_result_s;
  end

  // Control state: switch synchroniser, load response, misalign pulse and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      ld_data_r  <= 32'h0;
      ld_valid_r <= 1'b0;
      misalign_r <= 1'b0;
      ledr_r     <= 32'h0;
      ledg_r     <= 32'h0;
      lcd_r      <= 32'h0;
      hex_r      <= '0;
    end else begin
      sw_meta_r  <= io_sw_i;
      sw_sync_r  <= sw_meta_r;
      ld_valid_r <= bus.ld_en_i;
      misalign_r <= (bus.ld_en_i || bus.st_en_i) && !align_ok_s;
      if (bus.ld_en_i) ld_data_r <= ld_result_s;
      if (store_ok_s) begin
        if (is_ledr_s) ledr_r <= merge_be(ledr_r, wdata_rep_s, be_s);
        if (is_ledg_s) ledg_r <= merge_be(ledg_r, wdata_rep_s, be_s);
        if (is_lcd_s)  lcd_r  <= merge_be(lcd_r, wdata_rep_s, be_s);
        for (int i = 0; i < N_HEX; i++) begin
          if (is_hex_s && be_s[0] && (hex_idx_s == 3'(i))) hex_r[i] <= wdata_rep_s[6:0];
        end
      end
    end
  end

  // Data memory write port; contents survive reset but a store during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && store_ok_s && is_dmem_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) dmem_r[dmem_idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
      end
    end
  end

  assign bus.ld_data_o  = ld_data_r;
  assign bus.ld_valid_o = ld_valid_r;
  assign bus.misalign_o = misalign_r;
  assign io_ledr_o      = ledr_r;
  assign io_ledg_o      = ledg_r;
  assign io_lcd_o       = lcd_r;
  assign io_hex_o       = hex_r;

endmodule
